qed_issue_sequencer: RTL and testbench

QED_ISSUE_SEQUENCER -- requirements
Module: qed_issue_sequencer

---
 rtl/qed_issue_sequencer.sv | 74 +++++++
 tb/tb_qed_issue_sequencer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/qed_issue_sequencer.sv
// qed_issue_sequencer: issues originals into a replay buffer, then replays them as duplicates.
// Optional idle NOP issue is enabled by defining QED_NOP_FILL_EN.
module qed_issue_sequencer #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           ifu_instruction,
   input  logic                       ifu_valid,
   output logic                       ifu_ready,
   input  logic                       exec_dup,
   input  logic                       stall,
   output logic [WIDTH-1:0]           qic_qimux_instruction,
   output logic                       qed_dup,
   output logic                       qed_valid,
   output logic [$clog2(DEPTH):0]     qed_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [WIDTH-1:0] NOP = WIDTH'(32'h0000_0013);
   typedef enum logic {ORIG, DUP} state_t;
   state_t state, state_nxt;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, count_nxt;
   logic push, pop, fill, to_dup;
   logic valid_nxt, dup_nxt;
   logic [WIDTH-1:0] instr_nxt;
   assign ifu_ready = (state == ORIG) && !stall && (count < CW'(DEPTH));
   assign push      = ifu_valid && ifu_ready;
   assign pop       = (state == DUP) && !stall && (count != '0);
   assign count_nxt = count + CW'(push) - CW'(pop);
   assign qed_count = count;
`ifdef QED_NOP_FILL_EN
   assign fill = (state == ORIG) && !push;
`else
   assign fill = 1'b0;
`endif
   // exec_dup only counts when something (including a same-cycle push) is buffered
   assign to_dup = (count_nxt == CW'(DEPTH)) || (exec_dup && !stall && count_nxt != '0);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ORIG;
      else     state <= state_nxt;
   end
   always_comb begin
      state_nxt = (state == ORIG) ? (to_dup ? DUP : ORIG) : ((pop && count_nxt == '0) ? ORIG : DUP);
   end
   always_comb begin
      valid_nxt = push || pop || fill;
      dup_nxt   = pop;
      instr_nxt = push ? ifu_instruction : (pop ? mem[rd_ptr] : NOP);
   end
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= ifu_instruction;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr                <= '0;
         rd_ptr                <= '0;
         count                 <= '0;
         qed_valid             <= 1'b0;
         qed_dup               <= 1'b0;
         qic_qimux_instruction <= NOP;
      end else if (!stall) begin
         wr_ptr                <= wr_ptr + AW'(push);
         rd_ptr                <= rd_ptr + AW'(pop);
         count                 <= count_nxt;
         qed_valid             <= valid_nxt;
         qed_dup               <= dup_nxt;
         qic_qimux_instruction <= instr_nxt;
      end
   end
endmodule

// File: tb/tb_qed_issue_sequencer.sv
// tb_qed_issue_sequencer: directed checks of issue order, duplicate replay, stall and reset.
module tb_qed_issue_sequencer;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ifu_instruction;
   logic        ifu_valid, ifu_ready, exec_dup, stall;
   logic [31:0] qic_qimux_instruction;
   logic        qed_dup, qed_valid;
   logic [2:0]  qed_count;
   int checks = 0;
   int errors = 0;
`ifdef QED_NOP_FILL_EN
   localparam logic IDLE_VALID = 1'b1;
`else
   localparam logic IDLE_VALID = 1'b0;
`endif
   qed_issue_sequencer #(.DEPTH(4), .WIDTH(32)) dut (
      .clk(clk), .rst(rst), .ifu_instruction(ifu_instruction), .ifu_valid(ifu_valid),
      .ifu_ready(ifu_ready), .exec_dup(exec_dup), .stall(stall),
      .qic_qimux_instruction(qic_qimux_instruction), .qed_dup(qed_dup),
      .qed_valid(qed_valid), .qed_count(qed_count)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic push(input logic [31:0] v, input logic dup_req, input logic [2:0] cnt);
      ifu_valid = 1'b1;
      ifu_instruction = v;
      exec_dup = dup_req;
      step();
      ifu_valid = 1'b0;
      exec_dup = 1'b0;
      check("orig_instr", qic_qimux_instruction, v);
      check("orig_valid", 32'(qed_valid), 32'd1);
      check("orig_dup", 32'(qed_dup), 32'd0);
      check("orig_count", 32'(qed_count), 32'(cnt));
   endtask
   task automatic expect_dup(input logic [31:0] v, input logic [2:0] cnt);
      step();
      check("dup_instr", qic_qimux_instruction, v);
      check("dup_valid", 32'(qed_valid), 32'd1);
      check("dup_dup", 32'(qed_dup), 32'd1);
      check("dup_count", 32'(qed_count), 32'(cnt));
   endtask
   initial begin
      rst = 1'b1;
      ifu_instruction = '0;
      ifu_valid = 1'b0;
      exec_dup = 1'b0;
      stall = 1'b0;
      #12;
      check("rst_valid", 32'(qed_valid), 32'd0);
      check("rst_dup", 32'(qed_dup), 32'd0);
      check("rst_instr", qic_qimux_instruction, 32'h13);
      check("rst_count", 32'(qed_count), 32'd0);
      check("rst_ready", 32'(ifu_ready), 32'd1);
      @(posedge clk);
      #1 rst = 1'b0;
      // fill to full, then replay all four
      for (int i = 0; i < 4; i++) push(32'hA1 + 32'(i), 1'b0, 3'(i + 1));
      check("full_ready", 32'(ifu_ready), 32'd0);
      ifu_valid = 1'b1;
      ifu_instruction = 32'hEE;
      for (int i = 0; i < 4; i++) expect_dup(32'hA1 + 32'(i), 3'(3 - i));
      ifu_valid = 1'b0;
      check("back_orig_ready", 32'(ifu_ready), 32'd1);
      step();
      check("idle_valid", 32'(qed_valid), 32'(IDLE_VALID));
      check("idle_instr", qic_qimux_instruction, 32'h13);
      check("idle_dup", 32'(qed_dup), 32'd0);
      // early switch with a coincident push
      push(32'hB1, 1'b0, 3'd1);
      push(32'hB2, 1'b0, 3'd2);
      push(32'hB3, 1'b1, 3'd3);
      check("early_ready", 32'(ifu_ready), 32'd0);
      for (int i = 0; i < 3; i++) expect_dup(32'hB1 + 32'(i), 3'(2 - i));
      // stall mid-replay
      for (int i = 0; i < 4; i++) push(32'hD1 + 32'(i), 1'b0, 3'(i + 1));
      expect_dup(32'hD1, 3'd3);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_instr", qic_qimux_instruction, 32'hD1);
         check("stall_dup", 32'(qed_dup), 32'd1);
         check("stall_count", 32'(qed_count), 32'd3);
      end
      stall = 1'b0;
      for (int i = 1; i < 4; i++) expect_dup(32'hD1 + 32'(i), 3'(3 - i));
      // stall in ORIG blocks intake
      stall = 1'b1;
      #1 check("stall_ready", 32'(ifu_ready), 32'd0);
      stall = 1'b0;
      // asynchronous reset after two duplicates
      for (int i = 0; i < 4; i++) push(32'hE1 + 32'(i), 1'b0, 3'(i + 1));
      expect_dup(32'hE1, 3'd3);
      expect_dup(32'hE2, 3'd2);
      #2 rst = 1'b1;
      #1;
      check("arst_valid", 32'(qed_valid), 32'd0);
      check("arst_dup", 32'(qed_dup), 32'd0);
      check("arst_instr", qic_qimux_instruction, 32'h13);
      check("arst_count", 32'(qed_count), 32'd0);
      rst = 1'b0;
      push(32'hC1, 1'b0, 3'd1);
      exec_dup = 1'b1;
      step();
      exec_dup = 1'b0;
      check("c1_switch_valid", 32'(qed_valid), 32'(IDLE_VALID));
      expect_dup(32'hC1, 3'd0);
      // exec_dup with an empty buffer is ignored
      exec_dup = 1'b1;
      step();
      exec_dup = 1'b0;
      check("empty_dup_ready", 32'(ifu_ready), 32'd1);
      check("empty_dup_valid", 32'(qed_valid), 32'(IDLE_VALID));
      check("empty_dup_instr", qic_qimux_instruction, 32'h13);
      check("empty_dup_count", 32'(qed_count), 32'd0);
      // ten cycles, alternating 4 and 3 entries so pointers wrap misaligned
      for (int k = 0; k < 10; k++) begin
         int n;
         n = (k % 2 == 1) ? 3 : 4;
         for (int i = 0; i < n; i++)
            push(32'h100 * 32'(k) + 32'(i), (i == n - 1) && (n == 3), 3'(i + 1));
         for (int i = 0; i < n; i++) expect_dup(32'h100 * 32'(k) + 32'(i), 3'(n - 1 - i));
      end
      check("final_ready", 32'(ifu_ready), 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
